// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the I2C transaction arbiter.
//   arb_state_t            : arbiter FSM states
//   DEFAULT_TIMEOUT_CYCLES : default watchdog limit in clk cycles
//   RW_WRITE / RW_READ     : encoding of the per-requester direction bit
package i2c_arb_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        COMPLETE  = 3'd4
    } arb_state_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 16000;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_arbiter_rr_select.sv
// rr_select: combinational round-robin priority picker.
//   req  [NUM_REQ-1:0] : request vector
//   ptr  [PTR_W-1:0]   : index of the last granted requester
//   gnt  [NUM_REQ-1:0] : one-hot grant (all zero when no request)
// The search starts at ptr+1 and wraps to 0: requests above the pointer are
// served first; if none exist, the lowest-index request wins.
module rr_select #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt
);

    logic [NUM_REQ-1:0] upper_mask;
    logic [NUM_REQ-1:0] upper_req;
    logic [NUM_REQ-1:0] upper_gnt;
    logic [NUM_REQ-1:0] base_gnt;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
        assign upper_mask[gi] = (PTR_W'(gi) > ptr);
    end

    assign upper_req = req & upper_mask;

    // x & -x isolates the lowest set bit.
    assign upper_gnt = upper_req & (-upper_req);
    assign base_gnt  = req & (-req);

    assign gnt = (|upper_req) ? upper_gnt : base_gnt;

endmodule

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: shares one byte-level I2C controller among NUM_REQ requesters.
//   clk, rst (async, active-low)
//   req/req_rw/req_addr/req_wdata : per-requester transaction request
//   gnt  : one-hot grant, held from arbitration through the done cycle
//   done : one-cycle completion pulse, err : one-cycle timeout pulse
//   rdata: last read byte, updated only by completed reads
//   ctl_* : controller handshake (enable pulse, latched addr/data/rw,
//           ready/data_out back, ctl_rst watchdog reset pulse)
// Optional feature: define I2C_ARB_TIMEOUT_EN to enable the watchdog that
// aborts a stuck transaction after TIMEOUT_CYCLES cycles. Without it err and
// ctl_rst are constant 0 and the FSM waits indefinitely.
module i2c_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   req_rw,
    input  logic [NUM_REQ*7-1:0] req_addr,
    input  logic [NUM_REQ*8-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   done,
    output logic [NUM_REQ-1:0]   err,
    output logic [7:0]           rdata,
    output logic                 ctl_enable,
    output logic [6:0]           ctl_addr,
    output logic [7:0]           ctl_data_in,
    output logic                 ctl_rw,
    input  logic                 ctl_ready,
    input  logic [7:0]           ctl_data_out,
    output logic                 ctl_rst
);

    localparam int PTR_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("i2c_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
    end

    arb_state_t       state_reg;
    logic [PTR_W-1:0] ptr_reg;

    // Per-requester fields unpacked for readable selection.
    logic [6:0] addr_arr  [NUM_REQ];
    logic [7:0] wdata_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = req_addr[gi*7 +: 7];
        assign wdata_arr[gi] = req_wdata[gi*8 +: 8];
    end

    logic [NUM_REQ-1:0] sel_gnt;
    logic [PTR_W-1:0]   sel_idx;
    logic [6:0]         sel_addr;
    logic [7:0]         sel_wdata;
    logic               sel_rw;

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_select (
        .req (req),
        .ptr (ptr_reg),
        .gnt (sel_gnt)
    );

    // AND-OR mux driven by the one-hot pick.
    always_comb begin
        sel_idx   = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_rw    = RW_WRITE;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_gnt[i]) begin
                sel_idx   = PTR_W'(i);
                sel_addr  = addr_arr[i];
                sel_wdata = wdata_arr[i];
                sel_rw    = req_rw[i];
            end
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES - 1);

    // timer_reg = cycles elapsed since the ctl_enable cycle; it saturates at
    // TMR_LIMIT so ctl_rst lands exactly TIMEOUT_CYCLES after ctl_enable.
    logic [TMR_W-1:0] timer_reg;
    // Set in the ctl_rst cycle; the following edge completes with err.
    logic             timeout_reg;
`else
    assign err     = '0;
    assign ctl_rst = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            ptr_reg     <= PTR_W'(NUM_REQ - 1);
            gnt         <= '0;
            done        <= '0;
            rdata       <= '0;
            ctl_enable  <= 1'b0;
            ctl_addr    <= '0;
            ctl_data_in <= '0;
            ctl_rw      <= RW_WRITE;
`ifdef I2C_ARB_TIMEOUT_EN
            err         <= '0;
            ctl_rst     <= 1'b0;
            timer_reg   <= '0;
            timeout_reg <= 1'b0;
`endif
        end else begin
            // Pulse outputs default low.
            done       <= '0;
            ctl_enable <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
            err        <= '0;
            ctl_rst    <= 1'b0;
            if ((state_reg == WAIT_BUSY || state_reg == WAIT_DONE) &&
                timer_reg != TMR_LIMIT) begin
                timer_reg <= timer_reg + TMR_W'(1);
            end
`endif
            case (state_reg)
                IDLE: begin
                    if (|req && ctl_ready) begin
                        gnt         <= sel_gnt;
                        ptr_reg     <= sel_idx;
                        ctl_addr    <= sel_addr;
                        ctl_data_in <= sel_wdata;
                        ctl_rw      <= sel_rw;
                        // Registered so it is high during the ISSUE cycle.
                        ctl_enable  <= 1'b1;
                        state_reg   <= ISSUE;
                    end
                end

                ISSUE: begin
                    state_reg <= WAIT_BUSY;
`ifdef I2C_ARB_TIMEOUT_EN
                    timer_reg   <= TMR_W'(1);
                    timeout_reg <= 1'b0;
`endif
                end

                WAIT_BUSY: begin
`ifdef I2C_ARB_TIMEOUT_EN
                    if (timeout_reg) begin
                        done      <= gnt;
                        err       <= gnt;
                        state_reg <= COMPLETE;
                    end else
`endif
                    if (!ctl_ready) begin
                        state_reg <= WAIT_DONE;
                    end
`ifdef I2C_ARB_TIMEOUT_EN
                    else if (timer_reg == TMR_LIMIT) begin
                        ctl_rst     <= 1'b1;
                        timeout_reg <= 1'b1;
                    end
`endif
                end

                WAIT_DONE: begin
`ifdef I2C_ARB_TIMEOUT_EN
                    if (timeout_reg) begin
                        done      <= gnt;
                        err       <= gnt;
                        state_reg <= COMPLETE;
                    end else
`endif
                    if (ctl_ready) begin
                        if (ctl_rw == RW_READ) begin
                            rdata <= ctl_data_out;
                        end
                        done      <= gnt;
                        state_reg <= COMPLETE;
                    end
`ifdef I2C_ARB_TIMEOUT_EN
                    else if (timer_reg == TMR_LIMIT) begin
                        ctl_rst     <= 1'b1;
                        timeout_reg <= 1'b1;
                    end
`endif
                end

                COMPLETE: begin
                    // done is high this cycle; grant drops with it.
                    gnt       <= '0;
                    state_reg <= IDLE;
                end

                default: begin
                    gnt       <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
`timescale 1ns/1ps
module tb_i2c_arbiter;
    import i2c_arb_pkg::*;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TB_TIMEOUT = 100;
`else
    localparam int TB_TIMEOUT = 16000;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  req_rw;
    logic [27:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  gnt, done, err;
    logic [7:0]  rdata;
    logic        ctl_enable;
    logic [6:0]  ctl_addr;
    logic [7:0]  ctl_data_in;
    logic        ctl_rw;
    logic        ctl_ready;
    logic [7:0]  ctl_data_out;
    logic        ctl_rst;

    i2c_arbiter #(
        .NUM_REQ        (4),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_rw       (req_rw),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .gnt          (gnt),
        .done         (done),
        .err          (err),
        .rdata        (rdata),
        .ctl_enable   (ctl_enable),
        .ctl_addr     (ctl_addr),
        .ctl_data_in  (ctl_data_in),
        .ctl_rw       (ctl_rw),
        .ctl_ready    (ctl_ready),
        .ctl_data_out (ctl_data_out),
        .ctl_rst      (ctl_rst)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int onehot_bad = 0;
    int err_seen = 0;
    int ctl_rst_seen = 0;
    int done_seen = 0;

    // Controller model: on ctl_enable drop ready, stay busy busy_len cycles,
    // then raise ready with model_rdata. stuck=1 keeps ready high forever.
    int         busy_len    = 3;
    logic [7:0] model_rdata = 8'h00;
    bit         stuck       = 1'b0;

    always begin
        @(negedge clk);
        if (rst && ctl_enable && !stuck) begin
            ctl_ready    = 1'b0;
            ctl_data_out = 8'h00;
            repeat (busy_len) @(negedge clk);
            ctl_data_out = model_rdata;
            ctl_ready    = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (|err) err_seen++;
        if (ctl_rst) ctl_rst_seen++;
        if (|done) done_seen++;
    end

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic int oh_idx(logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic set_fields(input int idx, input logic rw, input logic [6:0] a,
                              input logic [7:0] wd);
        req_rw[idx]          = rw;
        req_addr[idx*7 +: 7] = a;
        req_wdata[idx*8 +: 8] = wd;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},   32'(gnt), 0);
        check({tag, "_done"},  32'(done), 0);
        check({tag, "_err"},   32'(err), 0);
        check({tag, "_rdata"}, 32'(rdata), 0);
        check({tag, "_en"},    32'(ctl_enable), 0);
        check({tag, "_addr"},  32'(ctl_addr), 0);
        check({tag, "_din"},   32'(ctl_data_in), 0);
        check({tag, "_rw"},    32'(ctl_rw), 0);
        check({tag, "_crst"},  32'(ctl_rst), 0);
    endtask

    // Runs until the next done pulse. mod_after_en > 0 applies
    // req = (req | set_m) & ~clr_m that many cycles after the ctl_enable cycle.
    task automatic next_txn(input int mod_after_en, input logic [3:0] set_m,
                            input logic [3:0] clr_m,
                            output int gidx, output int n_en,
                            output logic [6:0] a, output logic [7:0] d,
                            output logic rw, output logic [3:0] dn,
                            output logic [7:0] rd);
        bit ok = 1'b0;
        int en_c = -1;
        gidx = -1; n_en = 0; a = '0; d = '0; rw = 1'b0; dn = '0; rd = '0;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(negedge clk);
            if ($countones(gnt) > 1) onehot_bad++;
            if (ctl_enable) begin
                n_en++; en_c = c;
                a = ctl_addr; d = ctl_data_in; rw = ctl_rw; gidx = oh_idx(gnt);
            end
            if (|done) begin
                dn = done; rd = rdata; ok = 1'b1;
            end else if (mod_after_en > 0 && en_c >= 0 && c == en_c + mod_after_en) begin
                req = (req | set_m) & ~clr_m;
            end
        end
        check("txn_completes", 32'(ok), 1);
        $display("txn: grant=%0d addr=%h din=%h rw=%0d done=%b rdata=%h enables=%0d",
                 gidx, a, d, rw, dn, rd, n_en);
    endtask

    typedef struct {
        int         idx;
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic [7:0] mdata;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];
    int   rr_order[5];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int gidx, n_en;
        logic [6:0] a;
        logic [7:0] d, rd;
        logic rw;
        logic [3:0] dn, one;
        int got, done_before;

        one = 4'b0001;
        vecs[0] = '{0, RW_READ,  7'h50, 8'h11, 8'hA5, 8'hA5};
        vecs[1] = '{1, RW_WRITE, 7'h21, 8'h3C, 8'h77, 8'hA5};
        vecs[2] = '{3, RW_READ,  7'h7F, 8'hE0, 8'h00, 8'h00};
        vecs[3] = '{2, RW_READ,  7'h00, 8'h01, 8'hFF, 8'hFF};
        vecs[4] = '{2, RW_WRITE, 7'h44, 8'h99, 8'h12, 8'hFF};
        vecs[5] = '{0, RW_READ,  7'h12, 8'h34, 8'h5A, 8'h5A};
        rr_order = '{0, 1, 2, 3, 0};

        rst = 1'b0; req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
        ctl_ready = 1'b1; ctl_data_out = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // Single-requester transactions from the vector table.
        for (int v = 0; v < 6; v++) begin
            set_fields(vecs[v].idx, vecs[v].rw, vecs[v].addr, vecs[v].wdata);
            model_rdata = vecs[v].mdata;
            req = '0;
            req[vecs[v].idx] = 1'b1;
            next_txn(0, '0, '0, gidx, n_en, a, d, rw, dn, rd);
            req = '0;
            check("vec_grant",  32'(gidx), 32'(vecs[v].idx));
            check("vec_enables", 32'(n_en), 1);
            check("vec_addr",   32'(a), 32'(vecs[v].addr));
            check("vec_din",    32'(d), 32'(vecs[v].wdata));
            check("vec_rw",     32'(rw), 32'(vecs[v].rw));
            check("vec_done",   32'(dn), 32'(one << vecs[v].idx));
            check("vec_rdata",  32'(rd), 32'(vecs[v].exp_rdata));
        end

        // Round robin with all four held continuously, from a fresh reset.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) set_fields(i, RW_READ, 7'(8'h40 + i), 8'h00);
        model_rdata = 8'h5C;
        req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            next_txn(0, '0, '0, gidx, n_en, a, d, rw, dn, rd);
            check("rr_grant", 32'(gidx), 32'(rr_order[k]));
            check("rr_done",  32'(dn), 32'(one << rr_order[k]));
        end
        req = '0;
        check("rr_onehot", 32'(onehot_bad), 0);

        // req[2]/req[0] arrive while req[1] is busy; pointer is at 0.
        busy_len = 4;
        set_fields(1, RW_READ,  7'h11, 8'h00);
        set_fields(2, RW_WRITE, 7'h2C, 8'h3C);
        set_fields(0, RW_READ,  7'h0A, 8'h00);
        model_rdata = 8'hC3;
        req = 4'b0010;
        next_txn(1, 4'b0101, '0, gidx, n_en, a, d, rw, dn, rd);
        req = req & ~4'b0010;
        check("busy_first_grant", 32'(gidx), 1);
        check("busy_first_rdata", 32'(rd), 32'h0C3);
        model_rdata = 8'hEE;
        next_txn(0, '0, '0, gidx, n_en, a, d, rw, dn, rd);
        req = req & ~4'b0100;
        check("busy_next_grant", 32'(gidx), 2);
        check("busy_next_din",   32'(d), 32'h03C);
        check("busy_next_rw",    32'(rw), 32'(RW_WRITE));
        check("busy_write_rdata", 32'(rd), 32'h0C3);
        model_rdata = 8'h66;
        next_txn(0, '0, '0, gidx, n_en, a, d, rw, dn, rd);
        req = '0;
        check("busy_last_grant", 32'(gidx), 0);
        check("busy_last_rdata", 32'(rd), 32'h066);

        // req[3] dropped while the controller is busy.
        busy_len = 5;
        set_fields(3, RW_READ, 7'h7E, 8'h00);
        model_rdata = 8'h42;
        req = 4'b1000;
        next_txn(1, '0, 4'b1000, gidx, n_en, a, d, rw, dn, rd);
        check("drop_req_low",  32'(req), 0);
        check("drop_grant",    32'(gidx), 3);
        check("drop_done",     32'(dn), 32'h8);
        check("drop_rdata",    32'(rd), 32'h042);

        // Reset while waiting for the controller to finish.
        busy_len = 8;
        set_fields(2, RW_READ, 7'h2A, 8'h00);
        model_rdata = 8'h99;
        req = 4'b0100;
        got = 0;
        for (int c = 0; c < 50 && got == 0; c++) begin
            @(negedge clk);
            if (ctl_enable) got = 1;
        end
        check("rst_test_enable", 32'(got), 1);
        repeat (2) @(negedge clk);
        done_before = done_seen;
        rst = 1'b0;
        #1;
        check_all_zero("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        req = '0;
        got = 0;
        for (int c = 0; c < 50 && got == 0; c++) begin
            @(negedge clk);
            if (ctl_ready) got = 1;
        end
        check("rst_ctl_idle", 32'(got), 1);
        repeat (2) @(negedge clk);
        check("rst_no_done", 32'(done_seen), 32'(done_before));
        for (int i = 0; i < 4; i++) set_fields(i, RW_READ, 7'(8'h05 + i), 8'h00);
        model_rdata = 8'h81;
        busy_len = 3;
        req = 4'hF;
        next_txn(0, '0, '0, gidx, n_en, a, d, rw, dn, rd);
        req = '0;
        check("rst_next_grant", 32'(gidx), 0);
        check("rst_next_rdata", 32'(rd), 32'h081);

        check("no_err_pulse", 32'(err_seen), 0);
        check("no_ctl_rst",   32'(ctl_rst_seen), 0);

`ifdef I2C_ARB_TIMEOUT_EN
        begin : timeout_test
            int en_c, rst_c, dn_c, rst_cnt;
            logic [3:0] er;
            en_c = -1; rst_c = -1; dn_c = -1; rst_cnt = 0; er = '0; dn = '0; rd = '0;
            repeat (2) @(negedge clk);
            stuck = 1'b1;
            set_fields(1, RW_READ, 7'h33, 8'h00);
            req = 4'b0010;
            for (int c = 0; c < 400 && dn_c < 0; c++) begin
                @(negedge clk);
                if (ctl_enable) en_c = c;
                if (ctl_rst) begin rst_c = c; rst_cnt++; end
                if (|done) begin dn_c = c; dn = done; er = err; rd = rdata; end
            end
            req = '0;
            stuck = 1'b0;
            $display("txn: timeout enable@%0d ctl_rst@%0d done@%0d done=%b err=%b",
                     en_c, rst_c, dn_c, dn, er);
            check("to_rst_delay",  32'(rst_c - en_c), 100);
            check("to_done_delay", 32'(dn_c - rst_c), 1);
            check("to_rst_width",  32'(rst_cnt), 1);
            check("to_done",       32'(dn), 32'h2);
            check("to_err",        32'(er), 32'h2);
            check("to_rdata",      32'(rd), 32'h081);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
